alu_operand_stage: RTL and testbench

//  Decode->execute pipeline stage that directly feeds the ALU. Captures register-file

---
 rtl/alu_operand_stage.sv | 104 ++++++++++
 tb/tb_alu_operand_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// Decode->execute register stage feeding the ALU: operand-B mux, funct7 normalisation,
// valid/ready handshake with a one-entry skid buffer, branch flush and a stall counter.
module alu_operand_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_rs1_data,
    input  logic [XLEN-1:0]  in_rs2_data,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_use_imm,
    input  logic [2:0]       in_funct3,
    input  logic             in_funct7,
    input  logic [4:0]       in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_operandA,
    output logic [XLEN-1:0]  out_operandB,
    output logic [2:0]       out_funct3,
    output logic             out_funct7,
    output logic [4:0]       out_rd,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic [XLEN-1:0] op_a;
        logic [XLEN-1:0] op_b;
        logic [2:0]      f3;
        logic            f7;
        logic [4:0]      rd;
    } beat_t;

    beat_t m_q, s_q, in_beat;
    logic  m_valid, s_valid;
    logic  accept, m_free;

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        in_beat      = '0;
        in_beat.op_a = in_rs1_data;
        in_beat.op_b = in_use_imm ? in_imm : in_rs2_data;
        in_beat.f3   = in_funct3;
        // ADDI must never turn into a subtract, whatever bit 30 of the immediate holds.
        in_beat.f7   = (in_use_imm && in_funct3 == 3'b000) ? 1'b0 : in_funct7;
        in_beat.rd   = in_rd;
    end

    assign accept = in_valid & in_ready;
    assign m_free = ~m_valid | out_ready;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_q     <= '0;
        end else if (flush_i) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (m_free) begin
            s_valid <= 1'b0;
            if (s_valid) begin
                m_valid <= 1'b1;
                m_q     <= s_q;
            end else if (accept) begin
                m_valid <= 1'b1;
                m_q     <= in_beat;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (accept) begin
            s_valid <= 1'b1;
        end
    end

    // NOTE: skid data needs no reset; it is only ever read while s_valid is set.
    always_ff @(posedge clk) begin
        if (!flush_i && !m_free && accept) begin
            s_q <= in_beat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (m_valid && !out_ready && stall_cnt != {CNT_W{1'b1}}) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Skid occupancy is a flop, so in_ready never sees out_ready combinationally.
    assign in_ready     = ~s_valid;
    assign out_valid    = m_valid;
    assign out_operandA = m_q.op_a;
    assign out_operandB = m_q.op_b;
    assign out_funct3   = m_q.f3;
    assign out_funct7   = m_q.f7;
    assign out_rd       = m_q.rd;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed and scoreboarded checks for alu_operand_stage (built with CNT_W=4 so the
// stall counter saturates quickly).
module tb_alu_operand_stage;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush_i;
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_rs1_data, in_rs2_data, in_imm;
    logic             in_use_imm;
    logic [2:0]       in_funct3;
    logic             in_funct7;
    logic [4:0]       in_rd;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_operandA, out_operandB;
    logic [2:0]       out_funct3;
    logic             out_funct7;
    logic [4:0]       out_rd;
    logic [CNT_W-1:0] stall_cnt;

    alu_operand_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_operandA(out_operandA), .out_operandB(out_operandB),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_rd(out_rd),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rd;
    } exp_t;

    int n_checks = 0;
    int n_pass   = 0;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic use_imm, input logic [2:0] f3,
                         input logic f7, input logic [4:0] rd);
        in_valid = v; in_rs1_data = rs1; in_rs2_data = rs2; in_imm = imm;
        in_use_imm = use_imm; in_funct3 = f3; in_funct7 = f7; in_rd = rd;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; flush_i = 1'b0; out_ready = 1'b0;
        drive(1'b0, 0, 0, 0, 1'b0, 3'd0, 1'b0, 5'd0);
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    initial begin
        // 1: reset state and basic R-type beat
        do_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_opA", out_operandA, 32'd0);
        check("rst_opB", out_operandB, 32'd0);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        out_ready = 1'b1;
        drive(1'b1, 32'd5, 32'd3, 32'd0, 1'b0, 3'b000, 1'b1, 5'd7);
        step();
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_opA", out_operandA, 32'd5);
        check("t1_opB", out_operandB, 32'd3);
        check("t1_f7", 32'(out_funct7), 32'd1);
        check("t1_rd", 32'(out_rd), 32'd7);
        drive(1'b0, 0, 0, 0, 1'b0, 3'd0, 1'b0, 5'd0);
        step();
        check("t1_drained", 32'(out_valid), 32'd0);

        // 2: immediate select and ADDI funct7 normalisation
        drive(1'b1, 32'd1, 32'd9, 32'hFFFF_FFFC, 1'b1, 3'b000, 1'b1, 5'd2);
        step();
        check("t2_opB_imm", out_operandB, 32'hFFFF_FFFC);
        check("t2_addi_f7", 32'(out_funct7), 32'd0);
        drive(1'b1, 32'd1, 32'd9, 32'hFFFF_FFFC, 1'b1, 3'b001, 1'b1, 5'd2);
        step();
        check("t2_f3", 32'(out_funct3), 32'd1);
        check("t2_slli_f7", 32'(out_funct7), 32'd1);
        drive(1'b0, 0, 0, 0, 1'b0, 3'd0, 1'b0, 5'd0);
        step();

        // 3: back-pressure fills skid, then drains in order
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 32'd0, 32'd0, 1'b0, 3'd0, 1'b0, 5'd10);
        step();
        check("t3_A_valid", 32'(out_valid), 32'd1);
        check("t3_ready_1", 32'(in_ready), 32'd1);
        check("t3_stall0", 32'(stall_cnt), 32'd0);
        drive(1'b1, 32'hB, 32'd0, 32'd0, 1'b0, 3'd0, 1'b0, 5'd11);
        step();
        check("t3_ready_0", 32'(in_ready), 32'd0);
        check("t3_A_held", out_operandA, 32'hA);
        check("t3_stall1", 32'(stall_cnt), 32'd1);
        drive(1'b0, 0, 0, 0, 1'b0, 3'd0, 1'b0, 5'd0);
        step();
        check("t3_A_stable", out_operandA, 32'hA);
        check("t3_stall2", 32'(stall_cnt), 32'd2);
        out_ready = 1'b1;
        step();
        check("t3_B_out", out_operandA, 32'hB);
        check("t3_B_rd", 32'(out_rd), 32'd11);
        check("t3_ready_back", 32'(in_ready), 32'd1);
        check("t3_stall_hold", 32'(stall_cnt), 32'd2);
        step();
        check("t3_empty", 32'(out_valid), 32'd0);

        // 4: flush with both entries full and a beat offered
        out_ready = 1'b0;
        drive(1'b1, 32'hD, 32'd0, 32'd0, 1'b0, 3'd0, 1'b0, 5'd0);
        step();
        drive(1'b1, 32'hE, 32'd0, 32'd0, 1'b0, 3'd0, 1'b0, 5'd0);
        step();
        check("t4_full", 32'(in_ready), 32'd0);
        flush_i = 1'b1;
        drive(1'b1, 32'hC, 32'd0, 32'd0, 1'b0, 3'd0, 1'b0, 5'd0);
        step();
        flush_i = 1'b0;
        drive(1'b0, 0, 0, 0, 1'b0, 3'd0, 1'b0, 5'd0);
        check("t4_flush_valid", 32'(out_valid), 32'd0);
        check("t4_flush_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        step();
        check("t4_no_ghost", 32'(out_valid), 32'd0);
        // beat accepted on a flush cycle into an empty stage is dropped too
        flush_i = 1'b1;
        drive(1'b1, 32'hC, 32'd0, 32'd0, 1'b0, 3'd0, 1'b0, 5'd0);
        step();
        flush_i = 1'b0;
        check("t4_accept_dropped", 32'(out_valid), 32'd0);
        drive(1'b1, 32'hF, 32'd0, 32'd0, 1'b0, 3'd0, 1'b0, 5'd0);
        step();
        check("t4_after_flush", out_operandA, 32'hF);
        drive(1'b0, 0, 0, 0, 1'b0, 3'd0, 1'b0, 5'd0);
        step();

        // 5: 100 beats, random back-pressure, scoreboard order check
        begin
            int sent = 0, got = 0, cyc = 0;
            exp_t e;
            while (got < 100 && cyc < 3000) begin
                logic [31:0] r1, r2, im;
                logic ui, f7;
                logic [2:0] f3;
                r1 = $urandom; r2 = $urandom; im = $urandom;
                ui = 1'($urandom); f3 = 3'($urandom); f7 = 1'($urandom);
                out_ready = 1'($urandom_range(0, 1));
                drive(sent < 100 ? 1'($urandom_range(0, 3) != 0) : 1'b0,
                      r1, r2, im, ui, f3, f7, 5'(sent));
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("t5_unexpected_beat", 32'(out_rd), 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        check("t5_opA", out_operandA, e.a);
                        check("t5_opB", out_operandB, e.b);
                        check("t5_f3", 32'(out_funct3), 32'(e.f3));
                        check("t5_f7", 32'(out_funct7), 32'(e.f7));
                        check("t5_rd", 32'(out_rd), 32'(e.rd));
                    end
                    got++;
                end
                if (in_valid && in_ready) begin
                    e.a = r1; e.b = ui ? im : r2; e.f3 = f3;
                    e.f7 = (ui && f3 == 3'b000) ? 1'b0 : f7; e.rd = 5'(sent);
                    sb.push_back(e);
                    sent++;
                end
                step();
                cyc++;
            end
            check("t5_beats_out", got, 32'd100);
            check("t5_sb_empty", sb.size(), 32'd0);
        end
        drive(1'b0, 0, 0, 0, 1'b0, 3'd0, 1'b0, 5'd0);

        // 6: stall counter saturation and asynchronous reset
        do_reset();
        drive(1'b1, 32'h55, 32'd0, 32'd0, 1'b0, 3'd0, 1'b0, 5'd1);
        step();
        drive(1'b0, 0, 0, 0, 1'b0, 3'd0, 1'b0, 5'd0);
        repeat (20) step();
        check("t6_saturated", 32'(stall_cnt), 32'd15);
        check("t6_valid_held", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(out_valid), 32'd0);
        check("t6_async_stall", 32'(stall_cnt), 32'd0);
        check("t6_async_opA", out_operandA, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("t6_post_ready", 32'(in_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
